// File: rtl/shift_register_ctrl.sv
// Round-robin arbiter and sequencer feeding one shared chunk-serial shift register.
// A granted word is shifted in chunk 0 first, then presented with the owner's ID.
module shift_register_ctrl #(
  parameter  int CHUNK_WIDTH = 8,
  parameter  int REG_WIDTH   = 4,
  parameter  int NUM_REQ     = 2,
  localparam int ID_W        = $clog2(NUM_REQ),
  localparam int WORD_W      = REG_WIDTH * CHUNK_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*WORD_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [CHUNK_WIDTH-1:0]    sr_data_o,
  output logic                      sr_valid_o,
  input  logic [WORD_W-1:0]         sr_data_i,
  output logic                      out_valid_o,
  output logic [WORD_W-1:0]         out_data_o,
  output logic [ID_W-1:0]           out_id_o,
  input  logic                      out_ready_i,
  output logic [1:0]                dbg_state_o
);

  // Handshakes: a word moves on a rising edge where valid and ready are both high.
  // Requesters hold valid (and data) until that edge; ready never waits on a future valid.

  localparam int CNT_W = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_word;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_last;

  logic                w_grant_any;
  logic [ID_W-1:0]     w_grant_id;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic [WORD_W-1:0]   w_sel_word;
  logic [CHUNK_WIDTH-1:0] w_chunk;
  logic                w_accept;

  // Search starts just after the last winner, so the previous owner has lowest priority.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_grant_any && req_valid_i[(int'(r_last) + k) % NUM_REQ]) begin
        w_grant_any = 1'b1;
        w_grant_id  = ID_W'((int'(r_last) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_grant_oh = '0;
    if (w_grant_any) begin
      w_grant_oh[w_grant_id] = 1'b1;
    end
  end

  always_comb begin
    w_sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_word = req_data_i[i*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    w_chunk = '0;
    for (int i = 0; i < REG_WIDTH; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_chunk = r_word[i*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
  end

  assign w_accept = (r_state == ST_IDLE) && w_grant_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant_any)        w_next_state = ST_SHIFT;
      ST_SHIFT: if (r_cnt == CNT_LAST)  w_next_state = ST_DONE;
      ST_DONE:  if (out_ready_i)        w_next_state = ST_IDLE;
      default:                          w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_id   <= '0;
      r_last <= ID_W'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_word <= w_sel_word;
      r_id   <= w_grant_id;
      r_last <= w_grant_id;
      r_cnt  <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // The shift register only moves while sr_valid_o is high, so in DONE its
  // contents (and therefore out_data_o) stay put until the consumer takes them.
  always_comb begin
    req_ready_o = '0;
    sr_valid_o  = 1'b0;
    sr_data_o   = '0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_id_o    = '0;
    case (r_state)
      ST_IDLE: begin
        if (rst_n) begin
          req_ready_o = w_grant_oh;
        end
      end
      ST_SHIFT: begin
        sr_valid_o = 1'b1;
        sr_data_o  = w_chunk;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        out_data_o  = sr_data_i;
        out_id_o    = r_id;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = r_state;

endmodule
